// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W   = 64;
  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_NUM_RD   = 2;
  localparam int unsigned DEF_NUM_WR   = 2;

  // Smallest width able to index n entries.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(n)) res++;
    return res;
  endfunction

  // Low bit of port 'idx' inside a packed vector of 'width'-bit fields.
  function automatic int unsigned sliceLo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

  localparam int unsigned DEF_ADDR_W = clog2(DEF_NUM_REGS);

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared at writeback, set wins.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter int unsigned NUM_WR   = DEF_NUM_WR,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_WR-1:0]        i_we,
  input  logic [NUM_WR*ADDR_W-1:0] i_waddr,
  input  logic                     i_sb_set,
  input  logic [ADDR_W-1:0]        i_sb_addr,
  input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
  output logic [NUM_RD-1:0]        o_rbusy,
  output logic [NUM_REGS-1:0]      o_busy_vec
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] clr;
  logic [NUM_REGS-1:0] set;

  // Decode writeback clears and issue sets per register; out-of-range indices match nothing.
  always_comb begin
    clr = '0;
    set = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (i_we[w] && (i_waddr[sliceLo(w, ADDR_W) +: ADDR_W] == ADDR_W'(r))) clr[r] = 1'b1;
      end
      if (i_sb_set && (i_sb_addr == ADDR_W'(r)) && !((ZERO_REG != 0) && (r == 0))) set[r] = 1'b1;
    end
  end

  // Busy state: a same-cycle set overrides the clear (new producer outstanding).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) busy <= '0;
    else          busy <= set | (busy & ~clr);
  end

  // Read-port busy flags see this cycle's clears but not this cycle's sets.
  always_comb begin
    o_rbusy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (i_raddr[sliceLo(k, ADDR_W) +: ADDR_W] == ADDR_W'(r)) o_rbusy[k] = busy[r] & ~clr[r];
      end
    end
  end

  assign o_busy_vec = busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-through bypass, busy scoreboard and optional registered read.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = clog2(NUM_REGS),
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter int unsigned NUM_WR   = DEF_NUM_WR,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned READ_LAT = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_WR-1:0]        i_we,
  input  logic [NUM_WR*ADDR_W-1:0] i_waddr,
  input  logic [NUM_WR*DATA_W-1:0] i_wdata,
  input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
  output logic [NUM_RD*DATA_W-1:0] o_rdata,
  output logic [NUM_RD-1:0]        o_rbusy,
  input  logic                     i_sb_set,
  input  logic [ADDR_W-1:0]        i_sb_addr,
  output logic [NUM_REGS-1:0]      o_busy_vec
);

  logic [DATA_W-1:0]        regs  [NUM_REGS];
  logic [DATA_W-1:0]        wrVal [NUM_REGS];
  logic [NUM_REGS-1:0]      wrEn;
  logic [NUM_RD*DATA_W-1:0] rdComb;
  logic [NUM_RD-1:0]        rbusyComb;

  // Per-register write resolve: ascending port scan so the highest enabled port wins.
  always_comb begin
    wrEn = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      wrVal[r] = '0;
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (i_we[w] && (i_waddr[sliceLo(w, ADDR_W) +: ADDR_W] == ADDR_W'(r))) begin
          wrEn[r]  = 1'b1;
          wrVal[r] = i_wdata[sliceLo(w, DATA_W) +: DATA_W];
        end
      end
      if ((ZERO_REG != 0) && (r == 0)) wrEn[r] = 1'b0;
    end
  end

  // Architectural storage; a hardwired zero register is never written so it holds its reset 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (wrEn[r]) regs[r] <= wrVal[r];
      end
    end
  end

  // Bypass mux: the resolved write value takes precedence over stored state; no match reads 0.
  always_comb begin
    rdComb = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (i_raddr[sliceLo(k, ADDR_W) +: ADDR_W] == ADDR_W'(r)) begin
          rdComb[sliceLo(k, DATA_W) +: DATA_W] = wrEn[r] ? wrVal[r] : regs[r];
        end
      end
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) uScoreboard (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_we       (i_we),
    .i_waddr    (i_waddr),
    .i_sb_set   (i_sb_set),
    .i_sb_addr  (i_sb_addr),
    .i_raddr    (i_raddr),
    .o_rbusy    (rbusyComb),
    .o_busy_vec (o_busy_vec)
  );

  if (READ_LAT == 0) begin : gCombRead
    // Combinational path is forced to 0 during reset so a live bypass cannot leak through.
    assign o_rdata = i_rst_n ? rdComb    : '0;
    assign o_rbusy = i_rst_n ? rbusyComb : '0;
  end else begin : gRegRead
    // Registered read stage captures the bypassed data and busy flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        o_rdata <= '0;
        o_rbusy <= '0;
      end else begin
        o_rdata <= rdComb;
        o_rbusy <= rbusyComb;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench: combinational-read and registered-read builds driven in lockstep.
module tb_regfile_mp_sb;

  localparam int DW = 64;
  localparam int NR = 32;
  localparam int AW = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   we = '0;
  logic [9:0]   waddr = '0;
  logic [127:0] wdata = '0;
  logic [9:0]   raddr = '0;
  logic         sbSet = 1'b0;
  logic [4:0]   sbAddr = '0;

  logic [127:0] rdata0, rdata1;
  logic [1:0]   rbusy0, rbusy1;
  logic [31:0]  busyVec0, busyVec1;

  int nChecks = 0;
  int nPass = 0;

  // Reference state: architectural registers and busy bits as plain arrays.
  logic [63:0] mReg [NR];
  logic        mBusy [NR];
  logic [63:0] curRd [2];
  logic [63:0] prevRd [2];
  logic        curBz [2];
  logic        prevBz [2];

  regfile_mp_sb #(.READ_LAT(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_raddr(raddr), .o_rdata(rdata0), .o_rbusy(rbusy0), .i_sb_set(sbSet),
    .i_sb_addr(sbAddr), .o_busy_vec(busyVec0)
  );

  regfile_mp_sb #(.READ_LAT(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_raddr(raddr), .o_rdata(rdata1), .o_rbusy(rbusy1), .i_sb_set(sbSet),
    .i_sb_addr(sbAddr), .o_busy_vec(busyVec1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] we_, input int wa0, input int wa1,
                       input logic [63:0] wd0, input logic [63:0] wd1,
                       input int ra0, input int ra1, input logic set_, input int sa);
    we     = we_;
    waddr  = {5'(wa1), 5'(wa0)};
    wdata  = {wd1, wd0};
    raddr  = {5'(ra1), 5'(ra0)};
    sbSet  = set_;
    sbAddr = 5'(sa);
  endtask

  function automatic int wAddrOf(input int w);
    return int'(waddr[w*AW +: AW]);
  endfunction

  // Read value: reg 0 is always 0; otherwise the last enabled matching write port, else stored.
  function automatic logic [63:0] modelRead(input int a);
    logic [63:0] v;
    if (a == 0) return '0;
    v = mReg[a];
    for (int w = 0; w < 2; w++) if (we[w] && wAddrOf(w) == a) v = wdata[w*DW +: DW];
    return v;
  endfunction

  function automatic logic modelBusy(input int a);
    logic b;
    b = mBusy[a];
    for (int w = 0; w < 2; w++) if (we[w] && wAddrOf(w) == a) b = 1'b0;
    return b;
  endfunction

  function automatic logic [31:0] modelVec();
    logic [31:0] v;
    for (int r = 0; r < NR; r++) v[r] = mBusy[r];
    return v;
  endfunction

  task automatic modelReset();
    for (int r = 0; r < NR; r++) begin
      mReg[r]  = '0;
      mBusy[r] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      prevRd[k] = '0;
      prevBz[k] = 1'b0;
    end
  endtask

  task automatic checkZero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s c_rd%0d", tag, k), rdata0[k*DW +: DW], '0);
      check($sformatf("%s r_rd%0d", tag, k), rdata1[k*DW +: DW], '0);
    end
    check({tag, " c_rbusy"}, 64'(rbusy0), '0);
    check({tag, " r_rbusy"}, 64'(rbusy1), '0);
    check({tag, " c_vec"}, 64'(busyVec0), '0);
    check({tag, " r_vec"}, 64'(busyVec1), '0);
  endtask

  // Called at a falling edge after inputs are driven: compares both builds against the model.
  task automatic checkNow(input string tag);
    #1;
    for (int k = 0; k < 2; k++) begin
      int a;
      a = int'(raddr[k*AW +: AW]);
      curRd[k] = modelRead(a);
      curBz[k] = modelBusy(a);
      check($sformatf("%s c_rd%0d", tag, k), rdata0[k*DW +: DW], curRd[k]);
      check($sformatf("%s c_bz%0d", tag, k), 64'(rbusy0[k]), 64'(curBz[k]));
      check($sformatf("%s r_rd%0d", tag, k), rdata1[k*DW +: DW], prevRd[k]);
      check($sformatf("%s r_bz%0d", tag, k), 64'(rbusy1[k]), 64'(prevBz[k]));
    end
    check({tag, " c_vec"}, 64'(busyVec0), 64'(modelVec()));
    check({tag, " r_vec"}, 64'(busyVec1), 64'(modelVec()));
  endtask

  // Clock edge: commit writes (reg 0 ignored), clear busy on writeback, then apply the issue set.
  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      prevRd[k] = curRd[k];
      prevBz[k] = curBz[k];
    end
    for (int w = 0; w < 2; w++) if (we[w] && wAddrOf(w) != 0) mReg[wAddrOf(w)] = wdata[w*DW +: DW];
    for (int w = 0; w < 2; w++) if (we[w]) mBusy[wAddrOf(w)] = 1'b0;
    if (sbSet && sbAddr != 0) mBusy[sbAddr] = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  we;
    int          wa0, wa1;
    logic [63:0] wd0, wd1;
    int          ra0, ra1;
    logic        set;
    int          sa;
    logic [63:0] e0, e1;
    logic        b0, b1;
  } vec_t;

  vec_t tbl [16];

  initial begin
    //           we     wa0 wa1 wd0        wd1     ra0 ra1 set sa  e0         e1         b0 b1
    tbl[0]  = '{2'b01, 5, 0, 64'hA5,   64'h0,  5, 5, 0, 0, 64'hA5,   64'hA5,   0, 0};
    tbl[1]  = '{2'b00, 0, 0, 64'h0,    64'h0,  5, 0, 0, 0, 64'hA5,   64'h0,    0, 0};
    tbl[2]  = '{2'b11, 7, 7, 64'h11,   64'h22, 7, 7, 0, 0, 64'h22,   64'h22,   0, 0};
    tbl[3]  = '{2'b00, 0, 0, 64'h0,    64'h0,  7, 6, 0, 0, 64'h22,   64'h0,    0, 0};
    tbl[4]  = '{2'b01, 0, 0, 64'hFF,   64'h0,  0, 0, 0, 0, 64'h0,    64'h0,    0, 0};
    tbl[5]  = '{2'b00, 0, 0, 64'h0,    64'h0,  0, 5, 0, 0, 64'h0,    64'hA5,   0, 0};
    tbl[6]  = '{2'b00, 0, 0, 64'h0,    64'h0,  9, 9, 1, 9, 64'h0,    64'h0,    0, 0};
    tbl[7]  = '{2'b00, 0, 0, 64'h0,    64'h0,  9, 5, 0, 0, 64'h0,    64'hA5,   1, 0};
    tbl[8]  = '{2'b10, 0, 9, 64'h0,    64'h99, 9, 9, 0, 0, 64'h99,   64'h99,   0, 0};
    tbl[9]  = '{2'b00, 0, 0, 64'h0,    64'h0,  9, 9, 0, 0, 64'h99,   64'h99,   0, 0};
    tbl[10] = '{2'b01, 9, 0, 64'h55,   64'h0,  9, 9, 1, 9, 64'h55,   64'h55,   0, 0};
    tbl[11] = '{2'b00, 0, 0, 64'h0,    64'h0,  9, 9, 0, 0, 64'h55,   64'h55,   1, 1};
    tbl[12] = '{2'b00, 0, 0, 64'h0,    64'h0,  0, 0, 1, 0, 64'h0,    64'h0,    0, 0};
    tbl[13] = '{2'b00, 0, 0, 64'h0,    64'h0,  0, 9, 0, 0, 64'h0,    64'h55,   0, 1};
    tbl[14] = '{2'b01, 3, 0, 64'h1234, 64'h0,  3, 3, 0, 0, 64'h1234, 64'h1234, 0, 0};
    tbl[15] = '{2'b00, 0, 0, 64'h0,    64'h0,  3, 1, 0, 0, 64'h1234, 64'h0,    0, 0};

    modelReset();

    // Reset held with a live write/bypass/set on the inputs: every output must read 0.
    drive(2'b01, 5, 0, 64'hFACE, 64'h0, 5, 5, 1'b1, 5);
    #1 checkZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Post-reset sweep of all registers on both ports.
    for (int i = 0; i < NR; i++) begin
      drive(2'b00, 0, 0, '0, '0, i, NR - 1 - i, 1'b0, 0);
      checkNow($sformatf("sweep%0d", i));
      advance();
    end

    // Directed vectors.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].we, tbl[i].wa0, tbl[i].wa1, tbl[i].wd0, tbl[i].wd1,
            tbl[i].ra0, tbl[i].ra1, tbl[i].set, tbl[i].sa);
      checkNow($sformatf("vec%0d", i));
      check($sformatf("vec%0d t_rd0", i), rdata0[63:0], tbl[i].e0);
      check($sformatf("vec%0d t_rd1", i), rdata0[127:64], tbl[i].e1);
      check($sformatf("vec%0d t_bz0", i), 64'(rbusy0[0]), 64'(tbl[i].b0));
      check($sformatf("vec%0d t_bz1", i), 64'(rbusy0[1]), 64'(tbl[i].b1));
      advance();
    end

    // Registered read: data written and read in cycle N appears only in cycle N+1.
    drive(2'b01, 3, 0, 64'hBEEF, 64'h0, 3, 3, 1'b0, 0);
    checkNow("lat_n");
    check("lat_n r_rd0 old", rdata1[63:0], 64'h1234);
    advance();
    drive(2'b00, 0, 0, '0, '0, 1, 1, 1'b0, 0);
    checkNow("lat_n1");
    check("lat_n1 r_rd0 new", rdata1[63:0], 64'hBEEF);
    advance();

    // Randomised traffic on a narrow index range to provoke port conflicts and hazards.
    for (int i = 0; i < 500; i++) begin
      drive(2'($urandom), $urandom_range(0, 11), $urandom_range(0, 11),
            {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 11), $urandom_range(0, 31),
            1'($urandom_range(0, 2) == 0), $urandom_range(0, 11));
      checkNow($sformatf("rnd%0d", i));
      advance();
    end

    // Asynchronous reset mid-stream with a write and set in flight; both must be discarded.
    drive(2'b01, 4, 0, 64'hDEAD, 64'h0, 4, 4, 1'b1, 4);
    rst_n = 1'b0;
    #1 checkZero("midrst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    drive(2'b00, 0, 0, '0, '0, 4, 4, 1'b0, 0);
    checkNow("postrst");
    advance();

    for (int i = 0; i < 100; i++) begin
      drive(2'($urandom), $urandom_range(0, 31), $urandom_range(0, 31),
            {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 31), $urandom_range(0, 31),
            1'($urandom_range(0, 1)), $urandom_range(0, 31));
      checkNow($sformatf("rnd2_%0d", i));
      advance();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file for the pipelined core, with write-through bypass and an integrated per-register busy scoreboard.
It serves the decode stage: NUM_RD read ports and NUM_WR writeback ports, an optional hardwired zero register, and a selectable combinational or registered read path.
The scoreboard marks destination registers busy at issue and clears them at writeback, so decode can stall on RAW hazards without a separate hazard block.

Parameters:
DATA_W, 64, register width in bits
NUM_REGS, 32, number of architectural registers
ADDR_W, 5, register index width; must equal clog2(NUM_REGS)
NUM_RD, 2, number of read ports
NUM_WR, 2, number of write ports; higher index has priority
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never goes busy
READ_LAT, 0, 0 = combinational read; 1 = read data and busy flags registered (one-cycle latency)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_we  input  NUM_WR  write enable per write port
i_waddr  input  NUM_WR*ADDR_W  write index; port w occupies slice [w*ADDR_W +: ADDR_W]
i_wdata  input  NUM_WR*DATA_W  write data; port w occupies slice [w*DATA_W +: DATA_W]
i_raddr  input  NUM_RD*ADDR_W  read index per read port
o_rdata  output  NUM_RD*DATA_W  read data per read port
o_rbusy  output  NUM_RD  busy flag for each read port's register
i_sb_set  input  1  issue: mark i_sb_addr busy
i_sb_addr  input  ADDR_W  destination register of the issuing instruction
o_busy_vec  output  NUM_REGS  current scoreboard state (registered)

Behaviour:
- Reset (asynchronous, active-low; clock i_clk):
  - all registers, busy bits and (READ_LAT=1) output registers go to 0 immediately.
  - o_rdata = 0, o_rbusy = 0, o_busy_vec = 0 while i_rst_n is low.
  - Reset asserted mid-operation discards any in-flight write or set.
- Write, rising edge:
  - each port with i_we[w]=1 updates reg[i_waddr[w]].
  - Same index on several enabled ports: the highest w wins; the others are dropped.
  - ZERO_REG=1 and index 0: the write is ignored.
- Write-through bypass:
  - a read index matching an enabled write index in the same cycle returns that i_wdata, using the same priority.
  - Otherwise the read returns stored state.
  - Index 0 with ZERO_REG=1 always reads 0, including under bypass.
- Read latency:
  - READ_LAT=0: o_rdata and o_rbusy are combinational from i_raddr.
  - READ_LAT=1: the bypassed value and busy flag are captured at the rising edge and presented the next cycle.
- Scoreboard, per register r:
  - clear when any enabled write targets r.
  - set when i_sb_set=1 and i_sb_addr=r.
  - Set and clear on the same r in the same cycle: set wins (new producer is outstanding).
  - ZERO_REG=1: busy[0] stays 0.
  - Setting an already-busy register leaves it busy (single outstanding producer per register; no counting).
- o_rbusy[k] = busy[raddr_k] AND NOT (cleared by a write this cycle). A same-cycle set is not visible until the next cycle.
- Out-of-range index (≥ NUM_REGS when NUM_REGS < 2^ADDR_W): reads return 0 and busy 0; writes and sets are ignored.

Decomposition:
- Package regfile_pkg:
  - clog2 helper function.
  - default width and count constants.
  - slice-index helper functions for the packed port vectors.
- Sub-module regfile_scoreboard: busy vector, set/clear priority, o_rbusy generation.
- Top level: storage array, write-priority resolve, bypass muxes, READ_LAT output stage.

Test Plan:
- Reset, then read all 32 regs on both ports → o_rdata=0, o_rbusy=0, o_busy_vec=0.
- Write reg5=0xA5 on port0 while reading reg5 in the same cycle (READ_LAT=0) → o_rdata=0xA5 same cycle; next cycle a stored read returns 0xA5.
- Same-cycle conflict:
  - port0 writes reg7=0x11, port1 writes reg7=0x22 → bypass and stored value both 0x22.
  - write reg0=0xFF → reg0 reads 0.
- Scoreboard sequence:
  - i_sb_set reg9 → next cycle o_busy_vec[9]=1 and o_rbusy=1 for reads of reg9.
  - writeback to reg9 → o_rbusy drops in the write cycle; o_busy_vec[9]=0 next cycle.
  - set and write reg9 in the same cycle → busy stays 1.
- READ_LAT=1 build:
  - write reg3=0x1234 and read reg3 in cycle N → o_rdata=0x1234 appears in cycle N+1.
  - assert i_rst_n=0 mid-stream → outputs are 0 asynchronously before the next edge.
